// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: write-back select codes and FSM
// state encodings shared by the MEM pipeline stage.
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a req/ack
// data bus, with stall, alignment and timeout flags.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteMEM,
  input  logic        MemReadMEM,
  input  logic [1:0]  MemtoRegMEM,
  input  logic        RegWriteMEM,
  input  logic [31:0] ALUoutMEM,
  input  logic [31:0] memwritedataMEM,
  input  logic [4:0]  regwriteaddrMEM,
  input  logic [31:0] PCplus4MEM,
  input  logic [31:0] PCMEM,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        RegWriteWB,
  output logic [4:0]  regwriteaddrWB,
  output logic [31:0] regwritedataWB,
  output logic [31:0] PCWB,
  output logic        align_err,
  output logic        bus_err
);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_rw;
  logic [4:0]       r_rd;
  logic [31:0]      r_wbdata;
  logic [31:0]      r_pcwb;
  logic             r_aerr;
  logic             r_berr;

  logic             w_memop;
  logic             w_misal;
  logic             w_tmo;
  logic [31:0]      w_ldata;
  logic [31:0]      w_wbdata;

  assign w_memop = MemReadMEM | MemWriteMEM;
  assign w_misal = w_memop & (ALUoutMEM[1:0] != 2'b00);
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT - 1));

  // A combined read+write is treated as a store.
  assign w_ldata = (MemReadMEM & ~MemWriteMEM)
                 ? dmem_rdata : 32'd0;

  always_comb begin
    w_wbdata = ALUoutMEM;
    case (MemtoRegMEM)
      WB_MEM:  w_wbdata = w_ldata;
      WB_PC4:  w_wbdata = PCplus4MEM;
      default: w_wbdata = ALUoutMEM;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    case (r_state)
      IDLE:    mem_stall = w_memop & ~w_misal;
      BUSY:    mem_stall = ~dmem_ack & ~w_tmo;
      default: mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rw     <= 1'b0;
      r_rd     <= 5'd0;
      r_wbdata <= 32'd0;
      r_pcwb   <= 32'd0;
      r_aerr   <= 1'b0;
      r_berr   <= 1'b0;
    end else begin
      r_aerr <= 1'b0;
      r_berr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_memop && !w_misal) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteMEM;
            r_addr  <= {ALUoutMEM[31:2], 2'b00};
            r_wdata <= memwritedataMEM;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_state <= BUSY;
          end else if (w_misal) begin
            r_aerr <= 1'b1;
            r_rw   <= 1'b0;
            r_pcwb <= PCMEM;
          end else begin
            r_rw     <= RegWriteMEM;
            r_rd     <= regwriteaddrMEM;
            r_wbdata <= w_wbdata;
            r_pcwb   <= PCMEM;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (dmem_ack) begin
            r_req    <= 1'b0;
            r_rw     <= RegWriteMEM;
            r_rd     <= regwriteaddrMEM;
            r_wbdata <= w_wbdata;
            r_pcwb   <= PCMEM;
            r_state  <= IDLE;
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_berr  <= 1'b1;
            r_rw    <= 1'b0;
            r_pcwb  <= PCMEM;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign RegWriteWB     = r_rw;
  assign regwriteaddrWB = r_rd;
  assign regwritedataWB = r_wbdata;
  assign PCWB           = r_pcwb;
  assign align_err      = r_aerr;
  assign bus_err        = r_berr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of the MEM stage
// with a hand-driven data-memory responder.
module tb_mem_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteMEM, MemReadMEM;
  logic [1:0]  MemtoRegMEM;
  logic        RegWriteMEM;
  logic [31:0] ALUoutMEM, memwritedataMEM;
  logic [4:0]  regwriteaddrMEM;
  logic [31:0] PCplus4MEM, PCMEM;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        RegWriteWB;
  logic [4:0]  regwriteaddrWB;
  logic [31:0] regwritedataWB, PCWB;
  logic        align_err, bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .MemWriteMEM(MemWriteMEM), .MemReadMEM(MemReadMEM),
    .MemtoRegMEM(MemtoRegMEM), .RegWriteMEM(RegWriteMEM),
    .ALUoutMEM(ALUoutMEM), .memwritedataMEM(memwritedataMEM),
    .regwriteaddrMEM(regwriteaddrMEM), .PCplus4MEM(PCplus4MEM),
    .PCMEM(PCMEM), .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .RegWriteWB(RegWriteWB),
    .regwriteaddrWB(regwriteaddrWB),
    .regwritedataWB(regwritedataWB), .PCWB(PCWB),
    .align_err(align_err), .bus_err(bus_err)
  );

  task automatic clr_in();
    MemWriteMEM = 0; MemReadMEM = 0; MemtoRegMEM = 0;
    RegWriteMEM = 0; ALUoutMEM = 0; memwritedataMEM = 0;
    regwriteaddrMEM = 0; PCplus4MEM = 0; PCMEM = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr_in();
    PCMEM = 32'h77;
    RegWriteMEM = 1;
    reset = 1;
    tick(); tick();
    #1;
    n_tests++;
    if ({dmem_req, dmem_we, RegWriteWB, align_err, bus_err, mem_stall} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 000000", {dmem_req, dmem_we, RegWriteWB, align_err, bus_err, mem_stall});
    end
    n_tests++;
    if ({dmem_addr, dmem_wdata, regwritedataWB, PCWB, regwriteaddrWB} !== '0) begin
      n_fail++; $display("FAIL reset_data: addr %h wd %h wb %h pc %h rd %0d exp 0", dmem_addr, dmem_wdata, regwritedataWB, PCWB, regwriteaddrWB);
    end
    reset = 0;
    clr_in();
    tick();
  endtask

  task automatic test_alu();
    RegWriteMEM = 1; MemtoRegMEM = 0; ALUoutMEM = 32'h1234;
    regwriteaddrMEM = 5; PCMEM = 32'h200; PCplus4MEM = 32'h204;
    #1;
    n_tests++;
    if (mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL alu_stall: got %b exp 0", mem_stall);
    end
    tick();
    n_tests++;
    if ({RegWriteWB, regwriteaddrWB, regwritedataWB, PCWB} !== {1'b1, 5'd5, 32'h1234, 32'h200}) begin
      n_fail++; $display("FAIL alu_wb: we %b rd %0d d %h pc %h exp 1 5 1234 200", RegWriteWB, regwriteaddrWB, regwritedataWB, PCWB);
    end
    MemtoRegMEM = 3; ALUoutMEM = 32'h5A5A; regwriteaddrMEM = 9;
    tick();
    n_tests++;
    if (regwritedataWB !== 32'h5A5A || regwriteaddrWB !== 5'd9) begin
      n_fail++; $display("FAIL sel3_wb: d %h rd %0d exp 5a5a 9", regwritedataWB, regwriteaddrWB);
    end
    clr_in();
    tick();
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    MemReadMEM = 1; MemtoRegMEM = 1; RegWriteMEM = 1;
    ALUoutMEM = 32'h100; regwriteaddrMEM = 7; PCMEM = 32'h300;
    #1;
    if (mem_stall) stalls++;
    tick();
    n_tests++;
    if ({dmem_req, dmem_we, dmem_addr, RegWriteWB} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
      n_fail++; $display("FAIL load_req: req %b we %b a %h wbwe %b exp 1 0 100 0", dmem_req, dmem_we, dmem_addr, RegWriteWB);
    end
    dmem_ack = 1; dmem_rdata = 32'hCAFEBABE;
    #1;
    if (mem_stall) stalls++;
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    n_tests++;
    if (stalls !== 1) begin
      n_fail++; $display("FAIL load_stall_cycles: got %0d exp 1", stalls);
    end
    n_tests++;
    if ({dmem_req, RegWriteWB, regwriteaddrWB, regwritedataWB, PCWB} !== {1'b0, 1'b1, 5'd7, 32'hCAFEBABE, 32'h300}) begin
      n_fail++; $display("FAIL load_wb: req %b we %b rd %0d d %h pc %h exp 0 1 7 cafebabe 300", dmem_req, RegWriteWB, regwriteaddrWB, regwritedataWB, PCWB);
    end
    clr_in();
    tick();
  endtask

  task automatic test_store();
    int stalls;
    logic ok;
    stalls = 0; ok = 1;
    MemWriteMEM = 1; ALUoutMEM = 32'h20;
    memwritedataMEM = 32'hDEADBEEF; PCMEM = 32'h310;
    #1;
    if (mem_stall) stalls++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!(dmem_req && dmem_we && dmem_addr == 32'h20 && dmem_wdata == 32'hDEADBEEF)) ok = 0;
      dmem_ack = (i == 3);
      #1;
      if (mem_stall) stalls++;
    end
    tick();
    dmem_ack = 0;
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL store_bus: bus not stable at 1/1/20/deadbeef, last we %b wd %h", dmem_we, dmem_wdata);
    end
    n_tests++;
    if (stalls !== 4) begin
      n_fail++; $display("FAIL store_stall_cycles: got %0d exp 4", stalls);
    end
    n_tests++;
    if ({dmem_req, RegWriteWB, PCWB} !== {1'b0, 1'b0, 32'h310}) begin
      n_fail++; $display("FAIL store_done: req %b we %b pc %h exp 0 0 310", dmem_req, RegWriteWB, PCWB);
    end
    clr_in();
    tick();
  endtask

  task automatic test_both();
    MemWriteMEM = 1; MemReadMEM = 1; MemtoRegMEM = 1;
    RegWriteMEM = 1; ALUoutMEM = 32'h44; regwriteaddrMEM = 3;
    memwritedataMEM = 32'h11; PCMEM = 32'h320;
    tick();
    n_tests++;
    if (dmem_we !== 1'b1) begin
      n_fail++; $display("FAIL both_we: got %b exp 1", dmem_we);
    end
    dmem_ack = 1; dmem_rdata = 32'h55;
    tick();
    dmem_ack = 0;
    n_tests++;
    if ({RegWriteWB, regwritedataWB} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL both_wb: we %b d %h exp 1 0", RegWriteWB, regwritedataWB);
    end
    clr_in();
    tick();
  endtask

  task automatic test_misaligned();
    MemReadMEM = 1; MemtoRegMEM = 1; RegWriteMEM = 1;
    ALUoutMEM = 32'h102; regwriteaddrMEM = 4; PCMEM = 32'h500;
    #1;
    n_tests++;
    if (mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL mis_stall: got %b exp 0", mem_stall);
    end
    tick();
    n_tests++;
    if ({align_err, bus_err, dmem_req, RegWriteWB, PCWB} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h500}) begin
      n_fail++; $display("FAIL mis_flag: ae %b be %b req %b we %b pc %h exp 1 0 0 0 500", align_err, bus_err, dmem_req, RegWriteWB, PCWB);
    end
    clr_in();
    tick();
    n_tests++;
    if (align_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_pulse: got %b exp 0", align_err);
    end
  endtask

  task automatic test_timeout();
    int reqs, stalls;
    reqs = 0; stalls = 0;
    MemReadMEM = 1; MemtoRegMEM = 1; RegWriteMEM = 1;
    ALUoutMEM = 32'h40; regwriteaddrMEM = 6; PCMEM = 32'h600;
    tick();
    for (int i = 0; i < TMO; i++) begin
      if (dmem_req) reqs++;
      #1;
      if (mem_stall) stalls++;
      tick();
    end
    n_tests++;
    if (reqs !== TMO || stalls !== TMO - 1) begin
      n_fail++; $display("FAIL tmo_cycles: req %0d stall %0d exp %0d %0d", reqs, stalls, TMO, TMO - 1);
    end
    n_tests++;
    if ({dmem_req, bus_err, align_err, RegWriteWB, PCWB} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h600}) begin
      n_fail++; $display("FAIL tmo_abort: req %b be %b ae %b we %b pc %h exp 0 1 0 0 600", dmem_req, bus_err, align_err, RegWriteWB, PCWB);
    end
    clr_in();
    tick();
    n_tests++;
    if (bus_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse: got %b exp 0", bus_err);
    end
    MemReadMEM = 1; ALUoutMEM = 32'h80; PCMEM = 32'h610;
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    clr_in();
    #1;
    n_tests++;
    if ({dmem_req, dmem_we, dmem_addr, RegWriteWB, PCWB, bus_err, mem_stall} !== '0) begin
      n_fail++; $display("FAIL rst_busy: req %b a %h we %b pc %h be %b st %b exp 0", dmem_req, dmem_addr, RegWriteWB, PCWB, bus_err, mem_stall);
    end
    stalls = 0;
    for (int i = 0; i < TMO + 2; i++) begin
      tick();
      if (bus_err || RegWriteWB) stalls++;
    end
    n_tests++;
    if (stalls !== 0) begin
      n_fail++; $display("FAIL rst_after: %0d cycles with bus_err/wb, exp 0", stalls);
    end
  endtask

  task automatic test_ack_at_timeout();
    MemReadMEM = 1; MemtoRegMEM = 1; RegWriteMEM = 1;
    ALUoutMEM = 32'hC0; regwriteaddrMEM = 8; PCMEM = 32'h700;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    dmem_ack = 1; dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 0;
    n_tests++;
    if ({bus_err, RegWriteWB, regwriteaddrWB, regwritedataWB} !== {1'b0, 1'b1, 5'd8, 32'h0BADF00D}) begin
      n_fail++; $display("FAIL ack_tmo: be %b we %b rd %0d d %h exp 0 1 8 0badf00d", bus_err, RegWriteWB, regwriteaddrWB, regwritedataWB);
    end
    clr_in();
    tick();
  endtask

  task automatic test_jal();
    RegWriteMEM = 1; MemtoRegMEM = 2; ALUoutMEM = 32'h999;
    PCplus4MEM = 32'h404; PCMEM = 32'h400; regwriteaddrMEM = 31;
    tick();
    n_tests++;
    if ({RegWriteWB, regwriteaddrWB, regwritedataWB, PCWB} !== {1'b1, 5'd31, 32'h404, 32'h400}) begin
      n_fail++; $display("FAIL jal_wb: we %b rd %0d d %h pc %h exp 1 31 404 400", RegWriteWB, regwriteaddrWB, regwritedataWB, PCWB);
    end
    clr_in();
    tick();
  endtask

  initial begin
    reset = 1;
    clr_in();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_both();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_jal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, fed directly by the EX/MEM pipeline register outputs.
- Runs loads and stores over a variable-latency req/ack data-memory bus and asserts a stall while an access is outstanding.
- Selects the write-back value and registers it into MEM/WB outputs for the WB stage.
- Flags misaligned word accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max BUSY cycles to wait for dmem_ack before aborting (>=2)
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
MemWriteMEM  input  1  store request
MemReadMEM  input  1  load request
MemtoRegMEM  input  2  WB select: 0 ALUout, 1 load data, 2 PCplus4, 3 treated as 0
RegWriteMEM  input  1  register write enable
ALUoutMEM  input  32  ALU result / memory byte address
memwritedataMEM  input  32  store data
regwriteaddrMEM  input  5  destination register
PCplus4MEM  input  32  PC+4 (link value)
PCMEM  input  32  instruction PC
mem_stall  output  1  hold IF..EX/MEM this cycle
dmem_req  output  1  bus request, registered
dmem_we  output  1  1 = write, registered
dmem_addr  output  32  word address, registered
dmem_wdata  output  32  store data, registered
dmem_rdata  input  32  load data, valid with dmem_ack
dmem_ack  input  1  access complete, single-cycle pulse
RegWriteWB  output  1  WB write enable
regwriteaddrWB  output  5  WB destination
regwritedataWB  output  32  WB data
PCWB  output  32  PC of instruction in WB
align_err  output  1  one-cycle pulse: misaligned access dropped
bus_err  output  1  one-cycle pulse: access timed out

Behaviour:
- Clock and reset are clk and reset: one clock; reset is synchronous and active-high.
- Reset takes priority at the rising edge:
  - FSM goes to IDLE; counter clears.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata clear to 0.
  - All WB outputs clear to 0; align_err and bus_err clear to 0.
- Reset during BUSY abandons the access; no WB write and no error pulse follow.
- memop = MemReadMEM | MemWriteMEM. If both are set, the access is a store and load data is taken as 0.
- Misaligned = memop & ALUoutMEM[1:0] != 0.
- mem_stall is combinational:
  - 1 in IDLE when memop & !misaligned.
  - 1 in BUSY unless dmem_ack is high or the timeout is reached.
- FSM states: IDLE, BUSY.
- IDLE:
  - memop & !misaligned: register dmem_req=1, dmem_we=MemWriteMEM, dmem_addr={ALUoutMEM[31:2],2'b00}, dmem_wdata=memwritedataMEM; clear counter; go to BUSY. The WB stage gets a bubble: RegWriteWB<=0.
  - Misaligned: no bus request; align_err<=1 for one cycle; RegWriteWB<=0; PCWB<=PCMEM; stay in IDLE.
  - No memop: RegWriteWB<=RegWriteMEM, regwriteaddrWB<=regwriteaddrMEM, regwritedataWB<=mux(MemtoRegMEM), PCWB<=PCMEM. Latency is 1 cycle.
- BUSY:
  - dmem_* stay stable; the counter increments each cycle.
  - dmem_ack=1: load WB regs as in IDLE, with load data = dmem_rdata (0 for a store). Drop dmem_req; go to IDLE. The stall releases in this same cycle, so the upstream stage advances at this edge.
  - No ack and counter==TIMEOUT-1: drop dmem_req; bus_err<=1 for one cycle; RegWriteWB<=0; PCWB<=PCMEM; go to IDLE; stall releases.
  - An ack arriving in the timeout cycle wins: normal completion, no bus_err.
- A zero-wait memory costs exactly one stall cycle per access.
- Inputs are held stable by upstream while mem_stall=1. The block samples them only in IDLE and at completion.
- align_err and bus_err are never both 1.

Decomposition:
- Shared package: WB-select constants (WB_ALU=0, WB_MEM=1, WB_PC4=2) and FSM state encodings (IDLE, BUSY).
- No sub-module is required; the WB-select mux is inline.

Test Plan:
- ALU op, RegWriteMEM=1, MemtoReg=0, ALUout=0x1234, rd=5 -> next cycle RegWriteWB=1, regwriteaddrWB=5, regwritedataWB=0x1234, mem_stall never set.
- Load addr 0x100, ack in first BUSY cycle, rdata=0xCAFEBABE, MemtoReg=1 -> mem_stall high 1 cycle, dmem_addr=0x100, dmem_we=0, then regwritedataWB=0xCAFEBABE.
- Store addr 0x20, wdata 0xDEADBEEF, ack after 3 BUSY cycles -> dmem_we=1, dmem_wdata=0xDEADBEEF, mem_stall high 4 cycles, RegWriteWB=0.
- Load addr 0x102 -> align_err pulse 1 cycle, dmem_req stays 0, RegWriteWB=0, no stall.
- Load with no ack, TIMEOUT=16 -> dmem_req high 16 cycles then drops, bus_err pulse, stall released; then reset asserted mid-BUSY of next load -> dmem_req=0 and all outputs 0 after the edge.
- jal-style, MemtoReg=2, PCplus4=0x404, rd=31 -> regwritedataWB=0x404, regwriteaddrWB=31, PCWB=0x400.
